// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: assembles framed commands from a UART byte stream.
// Frame format: SYNC, cmd, len, len payload bytes, XOR checksum of cmd/len/payload.
// Ports:
//   clk, reset (async, active-low)
//   rx_done_tick, din     : received byte strobe and data
//   rd_addr, rd_data      : payload buffer read port (combinational read)
//   cmd, len, frame_valid : last valid frame and its one-cycle strobe
//   busy                  : parser is inside a frame
//   err_tick, err_code    : discard strobe and reason (1 checksum, 2 length, 3 timeout)
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter logic [7:0]  SYNC    = 8'hA5,
  localparam int unsigned AW     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_done_tick,
  input  logic [7:0]    din,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [7:0]    cmd,
  output logic [3:0]    len,
  output logic          frame_valid,
  output logic          busy,
  output logic          err_tick,
  output logic [1:0]    err_code
);

  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tmo_cnt;
  logic [AW-1:0] idx;
  logic [7:0]    shadow_cmd;
  logic [3:0]    shadow_len;
  logic [7:0]    chk;
  logic [7:0]    payload_q [DEPTH];

  logic          timeout_hit_c;
  logic          len_bad_c;
  logic          last_payload_c;
  logic          chk_ok_c;
  logic          fv_nx;
  logic          err_nx;
  logic [1:0]    code_nx;
  logic          commit_c;

  // A byte on the expiring cycle wins over the timeout.
  assign timeout_hit_c  = (state != S_IDLE) && !rx_done_tick &&
                          (tmo_cnt == TW'(TIMEOUT - 1));
  assign len_bad_c      = din > 8'(MAX_LEN);
  assign last_payload_c = (5'(idx) + 5'd1) == 5'(shadow_len);
  assign chk_ok_c       = din == chk;

  // Entries beyond MAX_LEN are never written and read back as zero.
  assign rd_data = payload_q[rd_addr];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    if (timeout_hit_c) begin
      state_nx = S_IDLE;
    end else if (rx_done_tick) begin
      case (state)
        S_IDLE:    if (din == SYNC) state_nx = S_CMD;
        S_CMD:     state_nx = S_LEN;
        S_LEN: begin
          if (len_bad_c)       state_nx = S_IDLE;
          else if (din == '0)  state_nx = S_CHK;
          else                 state_nx = S_PAYLOAD;
        end
        S_PAYLOAD: if (last_payload_c) state_nx = S_CHK;
        S_CHK:     state_nx = S_IDLE;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered strobes and error code
  always_comb begin
    fv_nx    = 1'b0;
    err_nx   = 1'b0;
    code_nx  = err_code;
    commit_c = 1'b0;
    if (timeout_hit_c) begin
      err_nx  = 1'b1;
      code_nx = ERR_TMO;
    end else if (rx_done_tick) begin
      case (state)
        S_LEN: begin
          if (len_bad_c) begin
            err_nx  = 1'b1;
            code_nx = ERR_LEN;
          end
        end
        S_CHK: begin
          if (chk_ok_c) begin
            fv_nx    = 1'b1;
            commit_c = 1'b1;
          end else begin
            err_nx  = 1'b1;
            code_nx = ERR_CHK;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_valid <= 1'b0;
      err_tick    <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
      cmd         <= '0;
      len         <= '0;
    end else begin
      frame_valid <= fv_nx;
      err_tick    <= err_nx;
      err_code    <= code_nx;
      busy        <= state_nx != S_IDLE;
      if (commit_c) begin
        cmd <= shadow_cmd;
        len <= shadow_len;
      end
    end
  end

  // Inter-byte timeout counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           tmo_cnt <= '0;
    else if (rx_done_tick || state == S_IDLE) tmo_cnt <= '0;
    else                                  tmo_cnt <= TW'(tmo_cnt + TW'(1));
  end

  // Frame datapath: shadow fields, running checksum, payload buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_cmd <= '0;
      shadow_len <= '0;
      chk        <= '0;
      idx        <= '0;
      for (int i = 0; i < int'(DEPTH); i++) payload_q[i] <= '0;
    end else if (rx_done_tick) begin
      case (state)
        S_CMD: begin
          shadow_cmd <= din;
          chk        <= din;
        end
        S_LEN: begin
          if (!len_bad_c) begin
            shadow_len <= din[3:0];
            chk        <= chk ^ din;
            idx        <= '0;
          end
        end
        S_PAYLOAD: begin
          payload_q[idx] <= din;
          chk            <= chk ^ din;
          idx            <= AW'(idx + AW'(1));
        end
        default: ;
      endcase
    end
  end

endmodule
